// File: rtl/ctrl_relogio.sv
// Clock-setting controller: RUN / SET_H / SET_M mode machine driving the
// seconds/minutes/hours counter enables. Define CTRL_AUTOREP_EN for inc auto-repeat.
module ctrl_relogio #(
  parameter logic [23:0] REP_DELAY  = 24'd5000000,
  parameter logic [23:0] REP_PERIOD = 24'd2500000
) (
  input  logic       ctrl_clock,
  input  logic       ctrl_reset,
  input  logic       ctrl_tick,
  input  logic       ctrl_modo,
  input  logic       ctrl_inc,
  input  logic       ctrl_s_max,
  input  logic       ctrl_m_max,
  output logic       ctrl_s_en,
  output logic       ctrl_s_add,
  output logic       ctrl_m_en,
  output logic       ctrl_m_add,
  output logic       ctrl_h_en,
  output logic       ctrl_h_add,
  output logic       ctrl_s_clr,
  output logic [1:0] ctrl_estado,
  output logic       ctrl_pisca
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   modo_prev_reg, inc_prev_reg;
  logic   s_pulse_reg, m_pulse_reg, h_pulse_reg, s_clr_reg, pisca_reg;
  logic   s_pulse_next, m_pulse_next, h_pulse_next, s_clr_next, pisca_next;
  logic   modo_edge, inc_edge, rep_fire, bump;

  assign modo_edge = ctrl_modo & ~modo_prev_reg;
  assign inc_edge  = ctrl_inc & ~inc_prev_reg;
  // A mode edge swallows any increment request in the same clock.
  assign bump      = ~modo_edge & (inc_edge | rep_fire);

`ifdef CTRL_AUTOREP_EN
  logic [23:0] rep_cnt_reg, rep_cnt_next;
  logic        rep_arm_reg, rep_arm_next;

  // Countdown armed by an inc edge; fires once after REP_DELAY, then every REP_PERIOD.
  always_comb begin
    rep_fire     = 1'b0;
    rep_arm_next = 1'b0;
    rep_cnt_next = '0;
    if (state_reg != RUN && !modo_edge && ctrl_inc) begin
      if (inc_edge) begin
        rep_arm_next = 1'b1;
        rep_cnt_next = REP_DELAY - 24'd1;
      end else if (rep_arm_reg) begin
        rep_arm_next = 1'b1;
        if (rep_cnt_reg == '0) begin
          rep_fire     = 1'b1;
          rep_cnt_next = REP_PERIOD - 24'd1;
        end else begin
          rep_cnt_next = rep_cnt_reg - 24'd1;
        end
      end
    end
  end

  always_ff @(posedge ctrl_clock) begin
    if (!ctrl_reset) begin
      rep_cnt_reg <= '0;
      rep_arm_reg <= 1'b0;
    end else begin
      rep_cnt_reg <= rep_cnt_next;
      rep_arm_reg <= rep_arm_next;
    end
  end
`else
  logic unused_params;
  assign unused_params = ^{REP_DELAY, REP_PERIOD};
  assign rep_fire      = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    s_pulse_next = 1'b0;
    m_pulse_next = 1'b0;
    h_pulse_next = 1'b0;
    s_clr_next   = 1'b1;
    pisca_next   = pisca_reg;
    case (state_reg)
      RUN: begin
        if (ctrl_tick) begin
          s_pulse_next = 1'b1;
          m_pulse_next = ctrl_s_max;
          h_pulse_next = ctrl_s_max & ctrl_m_max;
        end
        if (modo_edge) state_next = SET_H;
      end
      SET_H: begin
        if (modo_edge) state_next = SET_M;
        h_pulse_next = bump;
      end
      SET_M: begin
        if (modo_edge) begin
          state_next = RUN;
          s_clr_next = 1'b0;
        end
        m_pulse_next = bump;
      end
      default: state_next = RUN;
    endcase
    if (state_next != state_reg || state_reg == RUN) pisca_next = 1'b0;
    else if (ctrl_tick)                             pisca_next = ~pisca_reg;
  end

  // Previous-level bits reset high so a button held through reset is not an edge.
  always_ff @(posedge ctrl_clock) begin
    if (!ctrl_reset) begin
      state_reg     <= RUN;
      modo_prev_reg <= 1'b1;
      inc_prev_reg  <= 1'b1;
      s_pulse_reg   <= 1'b0;
      m_pulse_reg   <= 1'b0;
      h_pulse_reg   <= 1'b0;
      s_clr_reg     <= 1'b1;
      pisca_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      modo_prev_reg <= ctrl_modo;
      inc_prev_reg  <= ctrl_inc;
      s_pulse_reg   <= s_pulse_next;
      m_pulse_reg   <= m_pulse_next;
      h_pulse_reg   <= h_pulse_next;
      s_clr_reg     <= s_clr_next;
      pisca_reg     <= pisca_next;
    end
  end

  assign ctrl_s_en   = s_pulse_reg;
  assign ctrl_s_add  = s_pulse_reg;
  assign ctrl_m_en   = m_pulse_reg;
  assign ctrl_m_add  = m_pulse_reg;
  assign ctrl_h_en   = h_pulse_reg;
  assign ctrl_h_add  = h_pulse_reg;
  assign ctrl_s_clr  = s_clr_reg;
  assign ctrl_estado = state_reg;
  assign ctrl_pisca  = pisca_reg;

endmodule

// File: tb/tb_ctrl_relogio.sv
// Bench for ctrl_relogio: directed scenarios plus random stimulus against a
// behavioural model of the mode/increment rules (auto-repeat follows CTRL_AUTOREP_EN).
module tb_ctrl_relogio;

  localparam int DLY = 10;
  localparam int PER = 4;
`ifdef CTRL_AUTOREP_EN
  localparam bit          AUTOREP  = 1'b1;
  localparam logic [31:0] REP_MASK = 32'h0004_4401;
`else
  localparam bit          AUTOREP  = 1'b0;
  localparam logic [31:0] REP_MASK = 32'h0000_0001;
`endif

  logic       ctrl_clock = 1'b0;
  logic       ctrl_reset, ctrl_tick, ctrl_modo, ctrl_inc, ctrl_s_max, ctrl_m_max;
  logic       ctrl_s_en, ctrl_s_add, ctrl_m_en, ctrl_m_add, ctrl_h_en, ctrl_h_add;
  logic       ctrl_s_clr, ctrl_pisca;
  logic [1:0] ctrl_estado;

  always #5 ctrl_clock = ~ctrl_clock;

  ctrl_relogio #(.REP_DELAY(24'd10), .REP_PERIOD(24'd4)) dut (
    .ctrl_clock (ctrl_clock),
    .ctrl_reset (ctrl_reset),
    .ctrl_tick  (ctrl_tick),
    .ctrl_modo  (ctrl_modo),
    .ctrl_inc   (ctrl_inc),
    .ctrl_s_max (ctrl_s_max),
    .ctrl_m_max (ctrl_m_max),
    .ctrl_s_en  (ctrl_s_en),
    .ctrl_s_add (ctrl_s_add),
    .ctrl_m_en  (ctrl_m_en),
    .ctrl_m_add (ctrl_m_add),
    .ctrl_h_en  (ctrl_h_en),
    .ctrl_h_add (ctrl_h_add),
    .ctrl_s_clr (ctrl_s_clr),
    .ctrl_estado(ctrl_estado),
    .ctrl_pisca (ctrl_pisca)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_s, cnt_m, cnt_h, cnt_clr;

  // Model state: mode index 0..2, last button levels, blink, clocks inc held since its edge.
  int         md_mode;
  bit         md_pm, md_pi, md_pisca;
  int         md_held;
  logic [9:0] exp_vec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit tick, input bit modo, input bit inc,
                       input bit smax, input bit mmax);
    bit mr, ir, s, m, h, clr, due, go;
    int cur;
    if (!rst) begin
      md_mode  = 0;
      md_pm    = 1'b1;
      md_pi    = 1'b1;
      md_pisca = 1'b0;
      md_held  = -1;
      exp_vec  = 10'b00_0000_1000;
      return;
    end
    mr  = modo && !md_pm;
    ir  = inc && !md_pi;
    s   = 1'b0;
    m   = 1'b0;
    h   = 1'b0;
    clr = 1'b1;
    cur = -1;
    if (md_mode != 0 && !mr && inc) begin
      if (ir)                cur = 0;
      else if (md_held >= 0) cur = md_held + 1;
    end
    due     = AUTOREP && cur >= DLY && ((cur - DLY) % PER) == 0;
    md_held = cur;
    go      = !mr && (ir || due);
    case (md_mode)
      0: if (tick) begin
           s = 1'b1;
           m = smax;
           h = smax && mmax;
         end
      1: h = go;
      default: m = go;
    endcase
    if (mr && md_mode == 2) clr = 1'b0;
    if (mr || md_mode == 0) md_pisca = 1'b0;
    else if (tick)          md_pisca = !md_pisca;
    if (mr) md_mode = (md_mode + 1) % 3;
    md_pm   = modo;
    md_pi   = inc;
    exp_vec = {s, s, m, m, h, h, clr, 2'(md_mode), md_pisca};
  endtask

  task automatic cyc(input bit rst, input bit tick, input bit modo, input bit inc,
                     input bit smax, input bit mmax);
    @(negedge ctrl_clock);
    ctrl_reset = rst;
    ctrl_tick  = tick;
    ctrl_modo  = modo;
    ctrl_inc   = inc;
    ctrl_s_max = smax;
    ctrl_m_max = mmax;
    model(rst, tick, modo, inc, smax, mmax);
    @(posedge ctrl_clock);
    #1;
    check("cycle", {22'd0, ctrl_s_en, ctrl_s_add, ctrl_m_en, ctrl_m_add, ctrl_h_en,
                    ctrl_h_add, ctrl_s_clr, ctrl_estado, ctrl_pisca}, {22'd0, exp_vec});
    cnt_s   += int'(ctrl_s_add);
    cnt_m   += int'(ctrl_m_add);
    cnt_h   += int'(ctrl_h_add);
    cnt_clr += int'(!ctrl_s_clr);
  endtask

  task automatic clear_counts();
    cnt_s   = 0;
    cnt_m   = 0;
    cnt_h   = 0;
    cnt_clr = 0;
  endtask

  initial begin
    logic [31:0] mask;
    bit          r_modo, r_inc;
    ctrl_reset = 1'b0;
    ctrl_tick  = 1'b0;
    ctrl_modo  = 1'b0;
    ctrl_inc   = 1'b0;
    ctrl_s_max = 1'b0;
    ctrl_m_max = 1'b0;
    clear_counts();

    // Reset with mode held across release: no edge, stays in RUN
    repeat (3) cyc(0, 0, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 1, 0, 0, 0);
    check("reset_estado", 32'(ctrl_estado), 32'd0);
    check("reset_pulses", {29'd0, ctrl_s_add, ctrl_m_add, ctrl_h_add}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0);

    // Full carry on a tick
    cyc(1, 1, 0, 0, 1, 1);
    check("carry_all", {29'd0, ctrl_s_add, ctrl_m_add, ctrl_h_add}, 32'd7);
    cyc(1, 0, 0, 0, 1, 1);
    check("carry_width", {29'd0, ctrl_s_add, ctrl_m_add, ctrl_h_add}, 32'd0);

    // SET_H: three inc edges, ticks do not count seconds
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 1);
    end
    check("set_h_estado", 32'(ctrl_estado), 32'd1);
    check("set_h_count", 32'(cnt_h), 32'd3);
    check("set_h_sfrozen", 32'(cnt_s + cnt_m), 32'd0);

    // SET_M: two inc edges, then exit to RUN with seconds clear
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    clear_counts();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 1, 1, 1);
      cyc(1, 0, 0, 0, 0, 0);
    end
    check("set_m_count", 32'(cnt_m), 32'd2);
    check("set_m_no_carry", 32'(cnt_h + cnt_s), 32'd0);
    cyc(1, 0, 1, 0, 0, 0);
    check("exit_clr", 32'(ctrl_s_clr), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("exit_clr_width", 32'(cnt_clr), 32'd1);
    check("exit_estado", 32'(ctrl_estado), 32'd0);

    // Mode and inc edges together in SET_H
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    clear_counts();
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("simul_estado", 32'(ctrl_estado), 32'd2);
    check("simul_no_add", 32'(cnt_h + cnt_m), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Hold inc 22 clocks in SET_H
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    mask = '0;
    for (int j = 0; j < 27; j++) begin
      cyc(1, 0, 0, (j < 22), 0, 0);
      if (ctrl_h_add) mask[j] = 1'b1;
    end
    check("autorep_mask", mask, REP_MASK);

    // Reset while holding inc in SET_H abandons everything
    repeat (5) cyc(1, 0, 0, 1, 0, 0);
    clear_counts();
    repeat (2) cyc(0, 0, 0, 1, 0, 0);
    repeat (15) cyc(1, 0, 0, 1, 0, 0);
    check("reset_abandon", 32'(cnt_h + cnt_m + cnt_s), 32'd0);
    check("reset_abandon_estado", 32'(ctrl_estado), 32'd0);

    // Random traffic against the model
    r_modo = 1'b0;
    r_inc  = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 5) == 0)  r_modo = !r_modo;
      if ($urandom_range(0, 11) == 0) r_inc  = !r_inc;
      cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 3) == 0), r_modo, r_inc,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
